// File: rtl/mem_dump_reader.sv
// Read-only master for the data memory port: streams `count` consecutive words
// starting at `base_addr` out through a valid/ready interface.
module mem_dump_reader #(
   parameter int ADDR_LENGTH = 11,
   parameter int DATA_LENGTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_LENGTH-1:0] base_addr,
   input  logic [ADDR_LENGTH:0]   count,
   output logic [1:0]             WrRd,
   output logic [ADDR_LENGTH-1:0] addr,
   input  logic [DATA_LENGTH-1:0] mem_data,
   output logic [DATA_LENGTH-1:0] word,
   output logic                   word_valid,
   input  logic                   word_ready,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [1:0]           CMD_IDLE  = 2'b00;
   localparam logic [1:0]           CMD_READ  = 2'b01;
   localparam logic [ADDR_LENGTH:0] ONE_WORD  = {{ADDR_LENGTH{1'b0}}, 1'b1};
   localparam logic [ADDR_LENGTH-1:0] ADDR_STEP = {{(ADDR_LENGTH-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic [ADDR_LENGTH:0]   remaining_q, remaining_d;
   logic [ADDR_LENGTH-1:0] addr_d;
   logic [DATA_LENGTH-1:0] word_d;
   logic [1:0]             wrrd_d;
   logic                   valid_d;
   logic                   busy_d;
   logic                   done_d;

   // NOTE: every signal gets a default before the case so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      addr_d      = addr;
      word_d      = word;
      valid_d     = word_valid;
      wrrd_d      = CMD_IDLE;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            valid_d = 1'b0;
            if (start) begin
               addr_d      = base_addr;
               remaining_d = count;
               if (count == '0) begin
                  state_d = S_DONE;
               end else begin
                  wrrd_d  = CMD_READ;
                  state_d = S_REQ;
               end
            end
         end

         S_REQ: begin
            // the memory sampled addr on the negedge inside this cycle
            word_d  = mem_data;
            valid_d = 1'b1;
            state_d = S_SEND;
         end

         S_SEND: begin
            if (word_ready) begin
               remaining_d = remaining_q - ONE_WORD;
               addr_d      = addr + ADDR_STEP;
               valid_d     = 1'b0;
               if (remaining_q == ONE_WORD) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  wrrd_d  = CMD_READ;
                  state_d = S_REQ;
               end
            end
         end

         S_DONE: begin
            // A zero-count block enters DONE with done still low; it spends
            // one extra cycle here so the pulse lands one edge after start.
            if (!done) begin
               done_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed above.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         WrRd        <= CMD_IDLE;
         addr        <= '0;
         word        <= '0;
         word_valid  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         WrRd        <= wrrd_d;
         addr        <= addr_d;
         word        <= word_d;
         word_valid  <= valid_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: a behavioural memory, a ready driver,
// and a negedge monitor that checks reads and words against queued expectations.
module tb_mem_dump_reader;

   localparam int AL = 11;
   localparam int DL = 16;
   localparam int MEM_WORDS = 1 << AL;

   logic          clk;
   logic          rst;
   logic          start;
   logic [AL-1:0] base_addr;
   logic [AL:0]   count;
   logic [1:0]    WrRd;
   logic [AL-1:0] addr;
   logic [DL-1:0] mem_data;
   logic [DL-1:0] word;
   logic          word_valid;
   logic          word_ready;
   logic          busy;
   logic          done;

   mem_dump_reader #(.ADDR_LENGTH(AL), .DATA_LENGTH(DL)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .count      (count),
      .WrRd       (WrRd),
      .addr       (addr),
      .mem_data   (mem_data),
      .word       (word),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .busy       (busy),
      .done       (done)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [DL-1:0] mem [MEM_WORDS];
   logic [AL-1:0] req_q[$];
   logic [AL-1:0] waddr_q[$];
   logic [DL-1:0] word_q[$];
   int            rise_q[$];
   int            done_pulses = 0;
   int            exp_done    = 0;
   int            stall_seen  = 0;
   logic          prev_valid  = 1'b0;
   logic          prev_done   = 1'b0;

   int   ready_mode  = 0;
   int   stall_left  = 0;
   int   drv_words   = 0;
   logic drv_last_v  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: samples addr on the negedge of a READ cycle; otherwise junk data.
   always @(negedge clk) begin
      if (WrRd == 2'b01) mem_data <= mem[addr];
      else               mem_data <= DL'($urandom);
   end

   // Consumer: ready pattern chosen by the running test.
   initial begin
      word_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (word_valid && !drv_last_v) drv_words++;
         drv_last_v = word_valid;
         case (ready_mode)
            1: word_ready = 1'($urandom_range(0, 1));
            2: begin
               if (word_valid && drv_words == 2 && stall_left > 0) begin
                  word_ready = 1'b0;
                  stall_left--;
               end else begin
                  word_ready = 1'b1;
               end
            end
            default: word_ready = 1'b1;
         endcase
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (rst) begin
         prev_valid <= 1'b0;
         prev_done  <= 1'b0;
      end else begin
         check("wrrd_legal", 32'(WrRd != 2'b10), 1);
         if (WrRd == 2'b01) begin
            check("read_expected", 32'(req_q.size() != 0), 1);
            if (req_q.size() != 0) check("read_addr", 32'(addr), 32'(req_q.pop_front()));
         end
         if (word_valid) begin
            check("wrrd_idle_in_send", 32'(WrRd), 0);
            check("word_expected", 32'(word_q.size() != 0), 1);
            if (word_q.size() != 0) begin
               check("word", 32'(word), 32'(word_q[0]));
               check("word_addr", 32'(addr), 32'(waddr_q[0]));
               if (word_ready) begin
                  void'(word_q.pop_front());
                  void'(waddr_q.pop_front());
               end else begin
                  stall_seen++;
               end
            end
         end
         if (word_valid && !prev_valid) rise_q.push_back(cyc);
         if (done) begin
            done_pulses++;
            check("done_width", 32'(prev_done), 0);
         end
         prev_valid <= word_valid;
         prev_done  <= done;
      end
   end

   task automatic push_block(input logic [AL-1:0] b, input logic [AL:0] n);
      for (int i = 0; i < int'(n); i++) begin
         logic [AL-1:0] a;
         a = b + AL'(i);
         req_q.push_back(a);
         waddr_q.push_back(a);
         word_q.push_back(mem[a]);
      end
   endtask

   task automatic run_block(input logic [AL-1:0] b, input logic [AL:0] n,
                            output int e0, output int dcyc);
      @(negedge clk);
      check("idle_before_start", 32'(busy), 0);
      rise_q.delete();
      drv_words  = 0;
      stall_seen = 0;
      push_block(b, n);
      exp_done++;
      start     = 1'b1;
      base_addr = b;
      count     = n;
      @(posedge clk);
      #1;
      e0        = cyc;
      start     = 1'b0;
      base_addr = AL'($urandom);
      count     = (AL+1)'($urandom);
      check("busy_at_e0", 32'(busy), 1);
      dcyc = -1;
      for (int k = 0; k < 40 * int'(n) + 20 && dcyc < 0; k++) begin
         @(negedge clk);
         if (done) dcyc = cyc;
      end
      check("done_seen", 32'(dcyc >= 0), 1);
      @(negedge clk);
      check("busy_after_done", 32'(busy), 0);
      check("done_low_after", 32'(done), 0);
      check("queues_drained", 32'(req_q.size() + word_q.size()), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wrrd"}, 32'(WrRd), 0);
      check({tag, "_addr"}, 32'(addr), 0);
      check({tag, "_word"}, 32'(word), 0);
      check({tag, "_valid"}, 32'(word_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, dc;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = DL'(3 * i);
      rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Basic dump: words 15,18,21 at E1,E3,E5, done at E6
      ready_mode = 0;
      run_block(11'd5, 12'd3, e0, dc);
      check("basic_rises", 32'(rise_q.size()), 3);
      if (rise_q.size() == 3) begin
         check("basic_rise0", 32'(rise_q[0] - e0), 1);
         check("basic_rise1", 32'(rise_q[1] - e0), 3);
         check("basic_rise2", 32'(rise_q[2] - e0), 5);
      end
      check("basic_done_cycle", 32'(dc - e0), 6);

      // Backpressure: second word held for 4 cycles
      ready_mode = 2;
      stall_left = 4;
      run_block(11'd5, 12'd3, e0, dc);
      check("bp_stall_cycles", 32'(stall_seen), 4);
      check("bp_rises", 32'(rise_q.size()), 3);
      if (rise_q.size() == 3) check("bp_rise2", 32'(rise_q[2] - e0), 9);
      check("bp_done_cycle", 32'(dc - e0), 10);
      ready_mode = 0;

      // Zero count
      run_block(11'd100, 12'd0, e0, dc);
      check("zero_done_cycle", 32'(dc - e0), 1);
      check("zero_no_valid", 32'(rise_q.size()), 0);

      // Wrap across the top of memory
      run_block(11'd2046, 12'd4, e0, dc);
      check("wrap_done_cycle", 32'(dc - e0), 8);

      // Start while busy is ignored
      fork
         run_block(11'd5, 12'd3, e0, dc);
         begin
            for (int k = 0; k < 20 && !word_valid; k++) @(negedge clk);
            start = 1'b1; base_addr = 11'd100; count = 12'd7;
            @(negedge clk);
            start = 1'b0;
         end
      join
      repeat (3) begin
         @(negedge clk);
         check("busy_ignored_start", 32'(busy), 0);
      end

      // Reset mid-burst abandons the block without a done pulse
      ready_mode = 1;
      @(negedge clk);
      push_block(11'd10, 12'd20);
      start = 1'b1; base_addr = 11'd10; count = 12'd20;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midrst");
      @(negedge clk);
      check_all_zero("midrst2");
      req_q.delete(); waddr_q.delete(); word_q.delete();
      rst = 1'b0;
      check("no_done_on_reset", 32'(done_pulses), 32'(exp_done));
      run_block(11'd300, 12'd5, e0, dc);

      // Randomized blocks with random backpressure
      for (int t = 0; t < 12; t++) begin
         logic [AL:0] n;
         n = ($urandom_range(0, 3) == 0) ? '0 : (AL+1)'($urandom_range(1, 12));
         run_block(AL'($urandom), n, e0, dc);
      end

      // Full-memory dump at full throughput
      ready_mode = 0;
      run_block(AL'($urandom), 12'd2048, e0, dc);
      check("full_done_cycle", 32'(dc - e0), 4096);

      check("done_pulses", 32'(done_pulses), 32'(exp_done));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Read-side master for the data memory's `WrRd`/`addr`/`outData` port. It streams a block of `count` consecutive words, starting at `base_addr`, out through a valid/ready interface. The debug/UART path uses it to dump data memory after a program run. It never issues writes.

## Interface
- `ADDR_LENGTH`, 11, memory address width
- `DATA_LENGTH`, 16, memory word width

- `clk`  in  1  system clock; all state changes on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  start request, sampled only in IDLE
- `base_addr`  in  ADDR_LENGTH  first address, latched on accepted start
- `count`  in  ADDR_LENGTH+1  number of words, latched on accepted start; 0 is legal; max 2^ADDR_LENGTH
- `WrRd`  out  2  memory command: 2'b01 READ, 2'b00 idle; 2'b10 never driven
- `addr`  out  ADDR_LENGTH  memory address
- `mem_data`  in  DATA_LENGTH  memory read data (memory `outData`)
- `word`  out  DATA_LENGTH  captured word
- `word_valid`  out  1  `word` holds valid data
- `word_ready`  in  1  consumer accepts `word`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of block

## Operation
- All outputs are registered.
- States:
  - IDLE: `WrRd`=00, `word_valid`=0. On posedge with `start`=1: latch `base_addr` into `addr` and `count` into `remaining`. If `count`==0, go to DONE. Otherwise set `WrRd`=01 and go to REQ.
  - REQ: `WrRd`=01 held for exactly one cycle. The memory samples on the negedge inside this cycle. At the next posedge: `word`<=`mem_data`, `word_valid`<=1, `WrRd`<=00, go to SEND.
  - SEND: `word`, `word_valid` and `addr` hold until `word_ready`=1 at a posedge. On that handshake: `remaining`<=`remaining`-1 and `addr`<=`addr`+1.
    - If `remaining`==1, clear `word_valid` and go to DONE.
    - Otherwise clear `word_valid`, set `WrRd`=01 and go to REQ.
  - DONE: `done`=1 for this cycle only, then go to IDLE.
- `start` is ignored in every state other than IDLE.
- Address arithmetic is modulo 2^ADDR_LENGTH and wraps from all-ones to 0.
- `remaining` is ADDR_LENGTH+1 bits, so a full-memory dump (count = 2^ADDR_LENGTH) is supported.
- Each memory location is read exactly once per start. Backpressure never causes a re-read.

## Timing
- Reset (`rst`=1 at a posedge) forces state IDLE and clears all outputs: `WrRd`=00, `addr`=0, `word`=0, `word_valid`=0, `busy`=0, `done`=0.
- Reset mid-operation abandons the block. `WrRd` returns to 00 at that same edge, and no `done` pulse is generated.
- Let edge E0 be the edge where `start` is accepted:
  - `WrRd`=01 and `addr`=`base_addr` are driven from E0 until E1.
  - `word_valid`=1 with the first word from E1.
  - `busy`=1 from E0.
- Throughput: 2 cycles per word when `word_ready` is held high (REQ, SEND).
- After the last handshake at edge Ek, `done`=1 from Ek to Ek+1, and `busy`=0 from Ek+1. A new `start` is accepted at Ek+1 at the earliest.
- With `count`=0: `done`=1 from E1 to E2 and `busy`=0 from E2. `WrRd` is never 01.
- `addr` is stable for the whole REQ cycle, which meets the memory's negedge sampling. `mem_data` is captured only at the posedge that ends REQ.

## Test plan
- Reset: assert `rst` for 2 cycles mid-burst. At the next edge all outputs are 0 and the state is IDLE. No `done` pulse, and a new `start` is accepted right after.
- Basic dump: memory preloaded with mem[i]=3*i, `base_addr`=5, `count`=3, `word_ready`=1.
  - Words 15, 18, 21 appear with `word_valid` rising at E1, E3, E5.
  - `addr` sequence is 5, 6, 7.
  - `done` is high during E6–E7.
  - `WrRd` is never 10.
- Backpressure: same setup with `word_ready` low for 4 cycles on the second word. `word`=18 and `addr`=6 stay stable, `WrRd` stays 00 throughout the stall (no extra reads), and the sequence resumes correctly.
- Zero count: `start` with `count`=0. `done` pulses for one cycle at E1, `WrRd` stays 00, and `word_valid` stays 0.
- Wrap: ADDR_LENGTH=11, `base_addr`=2046, `count`=4. Addresses issued are 2046, 2047, 0, 1, and the words returned match the preload.
- Start while busy: pulse `start` with a different `base_addr` during SEND. It is ignored and the original block completes unchanged.
